// File: rtl/iiitb_fifo_pkg.sv
// Shared defaults and types for the FIFO read-side blocks.
package iiitb_fifo_pkg;

    localparam int unsigned DATA_WIDTH_DEFAULT = 8;
    localparam int unsigned LEN_WIDTH_DEFAULT  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } reader_state_e;

    typedef logic [1:0] occ_t;

endpackage

// File: rtl/iiitb_skid_buffer.sv
// Two-entry registered skid buffer; entry0 is always the head.
module iiitb_skid_buffer
    import iiitb_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_data_o,
    output occ_t                  occupancy_o
);

    logic [DATA_WIDTH-1:0] entry0_q, entry0_d;
    logic [DATA_WIDTH-1:0] entry1_q, entry1_d;
    occ_t                  occ_q, occ_d;
    logic                  pop_ok;
    logic                  push_ok;

    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        occ_d    = occ_q;
        pop_ok   = pop_i && (occ_q != 2'd0);
        // A push into a full buffer is only legal when the head leaves the same cycle.
        push_ok  = push_i && ((occ_q != 2'd2) || pop_ok);
        case ({push_ok, pop_ok})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    entry0_d = push_data_i;
                end else begin
                    entry1_d = push_data_i;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                entry0_d = entry1_q;
                occ_d    = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    entry0_d = push_data_i;
                end else begin
                    entry0_d = entry1_q;
                    entry1_d = push_data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            entry0_q <= '0;
            entry1_q <= '0;
            occ_q    <= 2'd0;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            occ_q    <= occ_d;
        end
    end

    assign head_data_o = entry0_q;
    assign occupancy_o = occ_q;

endmodule

// File: rtl/iiitb_fifo_reader.sv
// Burst drain engine: pops a programmed number of bytes from the FIFO into a valid/ready stream.
//   state | meaning
//   IDLE  | waiting for burst_Start, length captured on start
//   READ  | issuing pops while bytes remain and the skid has room
//   DRAIN | all pops issued, waiting for the sink to take the rest
//   DONE  | one-cycle burst_Done pulse, then back to IDLE
module iiitb_fifo_reader
    import iiitb_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int unsigned LEN_WIDTH  = LEN_WIDTH_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  burst_Start,
    input  logic [LEN_WIDTH-1:0]  burst_Length,
    output logic                  read_Enable,
    input  logic [DATA_WIDTH-1:0] buffer_Output,
    input  logic                  sig_Empty,
    output logic [DATA_WIDTH-1:0] data_Out,
    output logic                  sig_Valid,
    input  logic                  sig_Ready,
    output logic                  sig_Busy,
    output logic                  burst_Done
);

    localparam int unsigned CNT_WIDTH = LEN_WIDTH + 1;

    reader_state_e         state_q, state_d;
    logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
    logic                  inflight_q, inflight_d;
    occ_t                  occ;
    logic                  accept;
    logic [2:0]            pending;

    iiitb_skid_buffer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clock      (clock),
        .reset      (reset),
        .push_i     (inflight_q),
        .push_data_i(buffer_Output),
        .pop_i      (accept),
        .head_data_o(data_Out),
        .occupancy_o(occ)
    );

    assign sig_Valid = (occ != 2'd0);
    assign accept    = sig_Valid && sig_Ready;
    assign sig_Busy  = (state_q != IDLE);

    // Bytes already owed to the skid; one more pop must still fit after this cycle's accept.
    assign pending     = {1'b0, occ} + {2'b00, inflight_q};
    assign read_Enable = reset && (state_q == READ) && (remaining_q != '0) && !sig_Empty &&
                         (pending <= (accept ? 3'd2 : 3'd1));

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        inflight_d  = read_Enable;
        burst_Done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (burst_Start) begin
                    state_d     = READ;
                    remaining_d = (burst_Length == '0) ? (CNT_WIDTH'(1) << LEN_WIDTH)
                                                       : {1'b0, burst_Length};
                end
            end
            READ: begin
                if (read_Enable) begin
                    remaining_d = remaining_q - CNT_WIDTH'(1);
                    if (remaining_q == CNT_WIDTH'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!inflight_q && ((occ == 2'd0) || ((occ == 2'd1) && accept))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                burst_Done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
        end
    end

endmodule
